// File: rtl/div_seq_if.sv
// Purpose : request/response bundle between the EX stage and the sequential divider.
// Latency : n/a (wires only); the divider registers everything it drives.
// Backpr. : EX holds start_i until it sees ready_o and has consumed result_o.
//
// Signals: signed_div_i (1=DIV, 0=DIVU), opdata1_i (dividend), opdata2_i (divisor),
//          start_i (request level), annul_i (abort), result_o ({rem,quo}), ready_o.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    // EX stage side
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // divider side
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_seq.sv
// Purpose : radix-2 restoring divider for DIV/DIVU, one division in flight,
//           operands latched at the accepting edge (E0).
// Latency : ready_o 33 cycles after E0 (WIDTH iterations), 2 cycles for divide-by-zero,
//           1 cycle for |op1| < |op2| when DIV_SMALL_FAST_EN is defined.
// Backpr. : result held in END while start_i stays high; start_i low or annul_i returns to IDLE.
//
// Ports: clk, rst (synchronous, active high), div_if (slave modport of div_seq_if).
// Config: define DIV_SMALL_FAST_EN to finish small-dividend cases straight from IDLE.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    div_seq_if.slave      div_if
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 ready_q, ready_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    // Operand magnitudes; in unsigned mode they are the raw operands.
    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     mag1, mag2;

    // One restoring step on the working registers.
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     rem_nxt, quo_nxt;
    logic [WIDTH-1:0]     rem_fix, quo_fix;

    assign op1_neg = div_if.signed_div_i & div_if.opdata1_i[WIDTH-1];
    assign op2_neg = div_if.signed_div_i & div_if.opdata2_i[WIDTH-1];
    assign mag1    = op1_neg ? -div_if.opdata1_i : div_if.opdata1_i;
    assign mag2    = op2_neg ? -div_if.opdata2_i : div_if.opdata2_i;

    // rem < divisor holds every step, so the shifted value fits in WIDTH+1 bits
    // and diff[WIDTH] is the borrow of the trial subtraction.
    assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, dvs_q};
    assign rem_nxt = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nxt = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    // The most-negative / -1 case lands on 0x80..0 naturally after negation.
    assign quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
    assign rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready_d   = ready_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (div_if.start_i && !div_if.annul_i) begin
                    neg_quo_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                    dvs_d     = mag2;
                    quo_d     = mag1;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (div_if.opdata2_i == '0) begin
                        state_d = BYZERO;
                    end
`ifdef DIV_SMALL_FAST_EN
                    else if (mag1 < mag2) begin
                        // Quotient is zero and the remainder is the dividend as given.
                        state_d  = END;
                        ready_d  = 1'b1;
                        result_d = {div_if.opdata1_i, {WIDTH{1'b0}}};
                    end
`endif
                    else begin
                        state_d = ON;
                    end
                end
            end

            BYZERO: begin
                if (div_if.annul_i) begin
                    state_d = IDLE;
                end else begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end

            ON: begin
                if (div_if.annul_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d  = END;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end

            END: begin
                if (div_if.annul_i || !div_if.start_i) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign div_if.ready_o  = ready_q;
    assign div_if.result_o = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Purpose : self-checking bench for div_seq: directed cases plus randomized DIV/DIVU
//           against an arithmetic reference model.
// Latency : checks ready_o timing (33 / 2 / 1 cycles after the accepting edge).
// Backpr. : holds start_i through END, then releases it and checks the return to IDLE.
module tb_div_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: language division truncates toward zero with the remainder taking
    // the dividend's sign, which is exactly DIV; the one overflow case is pinned.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (b == 32'h0) return 64'h0;
        if (!sd) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
    endfunction

    function automatic int exp_lat(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint ma;
        longint mb;
        ma = (sd && a[31]) ? (64'sd4294967296 - longint'(a)) : longint'(a);
        mb = (sd && b[31]) ? (64'sd4294967296 - longint'(b)) : longint'(b);
        if (b == 32'h0) return 2;
`ifdef DIV_SMALL_FAST_EN
        if (ma < mb) return 1;
`else
        if (ma < 0 || mb < 0) return 0;
`endif
        return 33;
    endfunction

    // Issue one division, scramble the operand inputs after acceptance, measure
    // latency, check the held result for 'hold' cycles, then release start_i.
    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res, input int hold);
        int lat;
        @(negedge clk);
        bus.signed_div_i = sd;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        @(posedge clk);
        #1;
        lat = 1;
        bus.signed_div_i = ~sd;
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        while (!bus.ready_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat(sd, a, b)));
        chk({tag, " result"}, bus.result_o, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " held result"}, {bus.result_o[62:0], bus.ready_o}, {exp_res[62:0], 1'b1});
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " release"}, {bus.result_o[62:0], bus.ready_o}, 64'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        sd;
        logic        saw_ready;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 64'(bus.ready_o), 64'h0);
        chk("reset result", bus.result_o, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 1);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 0);
        run_div("div 5/0", 1'b1, 32'd5, 32'd0, 64'h0, 3);
        run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0);
        run_div("divu 3/10", 1'b0, 32'd3, 32'd10, {32'h3, 32'h0}, 1);
        run_div("div -3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, {32'hFFFF_FFFD, 32'h0}, 0);

        // Annul mid-iteration: request is dropped together with the abort.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o || bus.result_o != 64'h0) saw_ready = 1'b1;
        end
        chk("annul no ready", 64'(saw_ready), 64'h0);
        run_div("divu 9/4 after annul", 1'b0, 32'd9, 32'd4, {32'h1, 32'h2}, 0);

        // Annul while holding a finished result.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd50;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b1;
        repeat (3) @(negedge clk);
        chk("end before annul", 64'(bus.ready_o), 64'h1);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("annul in end", {bus.result_o[62:0], bus.ready_o}, 64'h0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;

        // Reset mid-iteration with start_i still asserted.
        @(negedge clk);
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst mid-run", {bus.result_o[62:0], bus.ready_o}, 64'h0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b0;
        run_div("divu 9/4 after rst", 1'b0, 32'd9, 32'd4, {32'h1, 32'h2}, 0);

        // Randomized operands with biased divisors.
        for (int n = 0; n < 40; n++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'($urandom_range(0, 200)); b = $urandom; end
                4: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            run_div("random", sd, a, b, model(sd, a, b), n % 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
